// File: rtl/sum_result_fifo_if.sv
// Handshake bundle between the registered-sum producer, the result FIFO and
// the downstream consumer.
interface sum_result_fifo_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    // The FIFO's view of the bundle.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );

    // The surrounding logic's view: drives the producer side and the ready.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/sum_result_fifo.sv
// First-word-fall-through result FIFO behind a producer that cannot be stalled.
// Words arriving while full are dropped and counted.
module sum_result_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    sum_result_fifo_if.slave    bus,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                empty,
    output logic [7:0]          drop_cnt,
    output logic                overflow
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;
    logic          push;
    logic          drop;

    assign full          = (count == CW'(DEPTH));
    assign empty         = (count == '0);
    assign bus.out_valid = !empty;
    assign bus.out_data  = mem[rd_ptr];

    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign pop  = bus.out_valid && bus.out_ready;
    assign push = bus.in_valid && (!full || pop) && !clr;
    assign drop = bus.in_valid && full && !pop && !clr;

    // Storage is deliberately left out of reset; only valid entries are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sum_result_fifo.sv
// Directed bench for sum_result_fifo: reset, FWFT latency, fill/drop/drain,
// full push+pop with pointer wrap, drop saturation with clr, async reset.
module tb_sum_result_fifo;
    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [7:0]    drop_cnt;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    sum_result_fifo_if #(.W(W)) bus ();

    sum_result_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .bus      (bus.slave),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .drop_cnt (drop_cnt),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || empty !== 1'b1 || count !== '0) begin
                failures++;
                $display("FAIL reset_hold: out_valid=%b empty=%b count=%0d, need 0/1/0",
                         bus.out_valid, empty, count);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || empty !== 1'b1 || count !== '0 ||
                drop_cnt !== 8'd0 || overflow !== 1'b0 || full !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle: ov=%b e=%b f=%b c=%0d d=%0d of=%b, need 0/1/0/0/0/0",
                         bus.out_valid, empty, full, count, drop_cnt, overflow);
            end
        end
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0123;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0123 || count !== CW'(1)) begin
            failures++;
            $display("FAIL single_visible: ov=%b data=%h count=%0d, need 1/0123/1",
                     bus.out_valid, bus.out_data, count);
        end
        tick();
        checks++;
        if (empty !== 1'b1 || count !== '0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drained: empty=%b count=%0d ov=%b, need 1/0/0",
                     empty, count, bus.out_valid);
        end
    endtask

    task automatic test_fill_drop_drain();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (count !== CW'(4) || full !== 1'b1 || drop_cnt !== 8'd2 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL fill_drop: count=%0d full=%b drop=%0d of=%b, need 4/1/2/1",
                     count, full, drop_cnt, overflow);
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'(i)) begin
                failures++;
                $display("FAIL drain_order[%0d]: ov=%b data=%h, need 1/%h",
                         i, bus.out_valid, bus.out_data, 16'(i));
            end
            tick();
        end
        checks++;
        if (empty !== 1'b1 || count !== '0) begin
            failures++;
            $display("FAIL drain_empty: empty=%b count=%0d, need 1/0", empty, count);
        end
        // Ready held high on an empty FIFO must not underflow.
        tick();
        checks++;
        if (empty !== 1'b1 || count !== '0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_underflow: empty=%b count=%0d ov=%b, need 1/0/0",
                     empty, count, bus.out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h0010 + 16'(i);
            tick();
        end
        checks++;
        if (full !== 1'b1 || bus.out_data !== 16'h0010) begin
            failures++;
            $display("FAIL pp_full: full=%b head=%h, need 1/0010", full, bus.out_data);
        end
        bus.in_data   = 16'h0014;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (count !== CW'(4) || drop_cnt !== 8'd2 || full !== 1'b1) begin
            failures++;
            $display("FAIL pp_same_cycle: count=%0d drop=%0d full=%b, need 4/2/1",
                     count, drop_cnt, full);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0010 + 16'(i)) begin
                failures++;
                $display("FAIL pp_order[%0d]: ov=%b data=%h, need 1/%h",
                         i, bus.out_valid, bus.out_data, 16'h0010 + 16'(i));
            end
            tick();
        end
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL pp_empty: empty=%b, need 1", empty);
        end
    endtask

    task automatic test_saturate_clr();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 16'h0020 + 16'(i);
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            bus.in_data = 16'h0100 + 16'(i);
            tick();
        end
        checks++;
        if (drop_cnt !== 8'd255 || overflow !== 1'b1 || count !== CW'(4) ||
            bus.out_data !== 16'h0020) begin
            failures++;
            $display("FAIL saturate: drop=%0d of=%b count=%0d head=%h, need 255/1/4/0020",
                     drop_cnt, overflow, count, bus.out_data);
        end
        clr         = 1'b1;
        bus.in_data = 16'h0BAD;
        tick();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (count !== '0 || drop_cnt !== 8'd0 || overflow !== 1'b0 ||
            empty !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clr: count=%0d drop=%0d of=%b empty=%b ov=%b, need 0/0/0/1/0",
                     count, drop_cnt, overflow, empty, bus.out_valid);
        end
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 16'h0030 + 16'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (count !== CW'(3)) begin
            failures++;
            $display("FAIL mid_prefill: count=%0d, need 3", count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== '0 || bus.out_valid !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL mid_async: count=%0d ov=%b empty=%b, need 0/0/1",
                     count, bus.out_valid, empty);
        end
        tick();
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h00AA;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h00AA || count !== CW'(1)) begin
            failures++;
            $display("FAIL mid_only_word: ov=%b data=%h count=%0d, need 1/00AA/1",
                     bus.out_valid, bus.out_data, count);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL mid_after: ov=%b empty=%b, need 0/1", bus.out_valid, empty);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_fill_drop_drain();
        test_full_push_pop();
        test_saturate_clr();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sum_result_fifo.md
Name: sum_result_fifo

Overview:
- Downstream consumer of the registered-sum stage.
- Captures every result word presented with its one-cycle valid pulse into a DEPTH-entry FIFO, then drains it to the next stage over a valid/ready handshake.
- The producer cannot be stalled, so words arriving while the FIFO is full are dropped and counted.
- Provides occupancy and status flags for monitoring.

Parameters:
- W, 16, width of result data word.
- DEPTH, 4, number of FIFO entries; power of two, DEPTH >= 2.
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- clr  input  1  synchronous flush of FIFO contents and statistics.
- in_valid  input  1  result word present this cycle (producer's valid).
- in_data  input  W  result word (producer's y).
- out_valid  output  1  FIFO head word available.
- out_ready  input  1  downstream accepts head word this cycle.
- out_data  output  W  FIFO head word.
- count  output  CW  current number of stored entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- drop_cnt  output  8  number of dropped input words, saturating at 255.
- overflow  output  1  sticky: at least one word dropped since reset or clr.

Behaviour:
- Reset (rst_n low, async): pointers = 0, count = 0, empty = 1, full = 0, out_valid = 0, drop_cnt = 0, overflow = 0. out_data is don't-care while empty; storage array is not reset.
- Cycle definitions:
  - pop = out_valid && out_ready.
  - push = in_valid && (!full || pop) && !clr.
  - drop = in_valid && full && !pop && !clr.
- out_valid = !empty. out_data = mem[rd_ptr], read combinationally from the register array (first-word-fall-through).
- Latency: a word pushed on edge N is visible on out_data with out_valid = 1 after edge N (cycle N+1) if the FIFO was empty.
- Ordering: strict FIFO. Words leave in arrival order with no duplication or loss except defined drops.
- Push: mem[wr_ptr] <= in_data; wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Pop: rd_ptr increments modulo DEPTH.
- count update:
  - +1 on push without pop.
  - -1 on pop without push.
  - unchanged on push with pop, or on neither.
- Simultaneous push and pop:
  - When full: both occur; count stays DEPTH and the new word is accepted.
  - When empty: pop cannot occur (out_valid = 0); push only.
- Drop: the word is discarded; drop_cnt increments unless it is 255 (held at 255); overflow <= 1.
- out_ready while empty: no effect; no underflow, pointers unchanged.
- clr (synchronous, highest priority):
  - Next state: pointers = 0, count = 0, drop_cnt = 0, overflow = 0.
  - An in_valid in the clr cycle is discarded and not counted as a drop.
  - A pop in the clr cycle still completes on the output side, but contents are flushed.
- Reset mid-operation: all state returns to reset values immediately. Stored words are lost; there is no partial output.
- out_valid must never be X after reset. count, full and empty are mutually consistent every cycle.

Test Plan:
- Reset hold 3 cycles, then release with no stimulus -> empty = 1, out_valid = 0, count = 0, drop_cnt = 0, overflow = 0 throughout.
- Single word, out_ready = 1: push in_data = 16'h0123 -> next cycle out_valid = 1, out_data = 16'h0123. Following cycle empty = 1, count = 0.
- Fill, then drop, then drain:
  - out_ready = 0; push 16'h0001..16'h0006 on consecutive cycles (DEPTH = 4) -> count = 4, full = 1, drop_cnt = 2, overflow = 1.
  - Then out_ready = 1 -> out_data sequence 0001, 0002, 0003, 0004, then empty = 1.
- Full with simultaneous push and pop: FIFO holds 0010..0013; drive out_ready = 1 and in_valid with 0014 in the same cycle -> drop_cnt unchanged, count stays 4. Drained order is 0011, 0012, 0013, 0014 (0010 is popped in that same cycle), exercising wr_ptr wrap.
- Saturation and clr:
  - Hold full, out_ready = 0, 300 in_valid cycles -> drop_cnt = 255, overflow = 1.
  - Pulse clr together with in_valid -> next cycle count = 0, drop_cnt = 0, overflow = 0, empty = 1.
- Mid-stream reset: with count = 3, assert rst_n low between clock edges -> count = 0, out_valid = 0 immediately, before the next edge. After release, a push of 16'h00AA is the only word output.
